manager_rx_fsm: RTL and testbench

Receive-side manager for the scoreboard's RS serial link. It consumes the byte stream delivered by the UART receiver and pairs consecutive bytes into an (address, data) command, first byte address, second byte data. This is the same framing the transmit manager produces. The block presents each completed pair to the register/display logic with a one-cycle valid strobe. It discards a half-received pair when the data byte does not arrive within a timeout, and counts such events.

---
 rtl/manager_rx_fsm.sv | 147 ++++++++++++++
 tb/tb_manager_rx_fsm.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/manager_rx_fsm.sv
// -----------------------------------------------------------------------------
// manager_rx_fsm
//
// Receive-side manager for the RS serial link. Pairs consecutive bytes from
// the UART receiver into (address, data) commands: first byte is the address,
// second byte is the data. Each completed pair is presented with a one-cycle
// rx_valid strobe. If the data byte does not follow the address within
// TIMEOUT_CYCLES clocks, the pending address is dropped, rx_timeout pulses and
// a saturating error counter is incremented.
//
// Parameters
//   TIMEOUT_CYCLES  max wait (clocks) for the data byte after the address (>= 2)
//   CNT_W           timeout counter width, 2**CNT_W > TIMEOUT_CYCLES
//
// Ports
//   CLK_50MHZ    in   1  system clock
//   RST_N        in   1  synchronous active-low reset
//   RS_DATAOUT   in   8  received byte, meaningful only while RS_TRG_READ = 1
//   RS_TRG_READ  in   1  single-cycle "new byte" strobe
//   addr_rx      out  8  address of the last completed pair
//   data_rx      out  8  data of the last completed pair
//   rx_valid     out  1  pulse: addr_rx/data_rx just updated
//   rx_timeout   out  1  pulse: pending address discarded
//   rx_busy      out  1  address held, waiting for data
//   err_cnt      out  8  saturating timeout count since reset
// -----------------------------------------------------------------------------
module manager_rx_fsm #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int CNT_W          = 16
) (
    input  logic       CLK_50MHZ,
    input  logic       RST_N,
    input  logic [7:0] RS_DATAOUT,
    input  logic       RS_TRG_READ,
    output logic [7:0] addr_rx,
    output logic [7:0] data_rx,
    output logic       rx_valid,
    output logic       rx_timeout,
    output logic       rx_busy,
    output logic [7:0] err_cnt
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ADDR = 2'd1,
        WAIT_DATA = 2'd2,
        DELIVER   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_reg,      state_next;
    logic [7:0]       addr_latch_reg, addr_latch_next;
    logic [CNT_W-1:0] cnt_reg,        cnt_next;
    logic [7:0]       addr_rx_reg,    addr_rx_next;
    logic [7:0]       data_rx_reg,    data_rx_next;
    logic             valid_reg,      valid_next;
    logic             timeout_reg,    timeout_next;
    logic             busy_reg,       busy_next;
    logic [7:0]       err_reg,        err_next;

    always_ff @(posedge CLK_50MHZ) begin
        if (!RST_N) begin
            state_reg      <= IDLE;
            addr_latch_reg <= 8'h00;
            cnt_reg        <= '0;
            addr_rx_reg    <= 8'h00;
            data_rx_reg    <= 8'h00;
            valid_reg      <= 1'b0;
            timeout_reg    <= 1'b0;
            busy_reg       <= 1'b0;
            err_reg        <= 8'h00;
        end else begin
            state_reg      <= state_next;
            addr_latch_reg <= addr_latch_next;
            cnt_reg        <= cnt_next;
            addr_rx_reg    <= addr_rx_next;
            data_rx_reg    <= data_rx_next;
            valid_reg      <= valid_next;
            timeout_reg    <= timeout_next;
            busy_reg       <= busy_next;
            err_reg        <= err_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        addr_latch_next = addr_latch_reg;
        cnt_next        = cnt_reg;
        addr_rx_next    = addr_rx_reg;
        data_rx_next    = data_rx_reg;
        valid_next      = 1'b0;
        timeout_next    = 1'b0;
        busy_next       = busy_reg;
        err_next        = err_reg;

        case (state_reg)
            IDLE: begin
                // Strobes here are deliberately ignored: one settling cycle after reset.
                state_next = WAIT_ADDR;
            end

            // DELIVER behaves like WAIT_ADDR so that back-to-back strobes never lose a byte.
            WAIT_ADDR, DELIVER: begin
                state_next = WAIT_ADDR;
                if (RS_TRG_READ) begin
                    addr_latch_next = RS_DATAOUT;
                    cnt_next        = '0;
                    busy_next       = 1'b1;
                    state_next      = WAIT_DATA;
                end
            end

            WAIT_DATA: begin
                // Data wins over a timeout expiring on the same edge.
                if (RS_TRG_READ) begin
                    addr_rx_next = addr_latch_reg;
                    data_rx_next = RS_DATAOUT;
                    valid_next   = 1'b1;
                    busy_next    = 1'b0;
                    state_next   = DELIVER;
                end else if (cnt_reg == CNT_LAST) begin
                    timeout_next = 1'b1;
                    busy_next    = 1'b0;
                    if (err_reg != 8'hFF) begin
                        err_next = err_reg + 8'd1;
                    end
                    state_next   = WAIT_ADDR;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign addr_rx    = addr_rx_reg;
    assign data_rx    = data_rx_reg;
    assign rx_valid   = valid_reg;
    assign rx_timeout = timeout_reg;
    assign rx_busy    = busy_reg;
    assign err_cnt    = err_reg;

endmodule

// File: tb/tb_manager_rx_fsm.sv
// -----------------------------------------------------------------------------
// tb_manager_rx_fsm
//
// Drives manager_rx_fsm (TIMEOUT_CYCLES = 8) with directed and random byte
// strobes. A reference model, written in terms of edge numbers (address edge,
// data edge, edge of timeout expiry), pushes expected pair/timeout events into
// a queue; an independent monitor on the falling edge pops and compares them
// whenever the DUT pulses rx_valid or rx_timeout, and also checks the held
// outputs every cycle.
// -----------------------------------------------------------------------------
module tb_manager_rx_fsm;

    localparam int T = 8;

    logic       CLK_50MHZ = 1'b0;
    logic       RST_N = 1'b0;
    logic [7:0] RS_DATAOUT = 8'h00;
    logic       RS_TRG_READ = 1'b0;
    logic [7:0] addr_rx;
    logic [7:0] data_rx;
    logic       rx_valid;
    logic       rx_timeout;
    logic       rx_busy;
    logic [7:0] err_cnt;

    manager_rx_fsm #(.TIMEOUT_CYCLES(T), .CNT_W(4)) dut (
        .CLK_50MHZ  (CLK_50MHZ),
        .RST_N      (RST_N),
        .RS_DATAOUT (RS_DATAOUT),
        .RS_TRG_READ(RS_TRG_READ),
        .addr_rx    (addr_rx),
        .data_rx    (data_rx),
        .rx_valid   (rx_valid),
        .rx_timeout (rx_timeout),
        .rx_busy    (rx_busy),
        .err_cnt    (err_cnt)
    );

    always #5 CLK_50MHZ = ~CLK_50MHZ;

    typedef struct {
        bit         is_valid;
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] e;
        int         edge_no;
    } ev_t;

    ev_t q[$];

    int vectors = 0;
    int miscompares = 0;
    int edge_num = 0;

    // Reference model state
    bit         model_live = 0;
    bit         pending = 0;
    logic [7:0] pend_addr = 0;
    int         addr_edge = 0;
    int         accept_from = 0;
    logic [7:0] exp_addr = 0;
    logic [7:0] exp_data = 0;
    logic [7:0] exp_err = 0;
    bit         exp_busy = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, edge_num);
        end
    endtask

    // Model: rules stated in edge numbers. A reset edge r allows addresses
    // from edge r+2 on; an address at edge a expires at edge a+T unless data
    // arrives at any edge a+1..a+T.
    task automatic model_edge(input bit rstn, input bit strb, input logic [7:0] d);
        if (!rstn) begin
            pending     = 0;
            accept_from = edge_num + 2;
            exp_addr    = 8'h00;
            exp_data    = 8'h00;
            exp_err     = 8'h00;
            exp_busy    = 0;
            model_live  = 1;
            return;
        end
        if (pending) begin
            if (strb) begin
                exp_addr = pend_addr;
                exp_data = d;
                q.push_back('{is_valid: 1'b1, a: pend_addr, d: d, e: exp_err, edge_no: edge_num});
                pending = 0;
            end else if (edge_num - addr_edge == T) begin
                if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
                q.push_back('{is_valid: 1'b0, a: exp_addr, d: exp_data, e: exp_err, edge_no: edge_num});
                pending = 0;
            end
        end else if (strb && edge_num >= accept_from) begin
            pending   = 1;
            pend_addr = d;
            addr_edge = edge_num;
        end
        exp_busy = pending;
    endtask

    // One clock of stimulus: inputs set, sampled at the next rising edge.
    task automatic step(input bit rstn, input bit strb, input logic [7:0] d);
        RST_N       = rstn;
        RS_TRG_READ = strb;
        RS_DATAOUT  = strb ? d : 8'($urandom);
        @(posedge CLK_50MHZ);
        edge_num++;
        model_edge(rstn, strb, d);
        #1;
        RS_TRG_READ = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'h00);
    endtask

    task automatic strobe(input logic [7:0] d);
        step(1'b1, 1'b1, d);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
    endtask

    // Monitor: per-cycle held outputs plus event scoreboard.
    always @(negedge CLK_50MHZ) begin
        if (model_live) begin
            ev_t e;
            check("rx_busy", {31'd0, rx_busy}, {31'd0, exp_busy});
            check("addr_rx", {24'd0, addr_rx}, {24'd0, exp_addr});
            check("data_rx", {24'd0, data_rx}, {24'd0, exp_data});
            check("err_cnt", {24'd0, err_cnt}, {24'd0, exp_err});
            while (q.size() > 0 && q[0].edge_no < edge_num) begin
                e = q.pop_front();
                vectors++;
                miscompares++;
                $display("FAIL missing_event: got none expected %s from edge %0d at edge %0d",
                         e.is_valid ? "rx_valid" : "rx_timeout", e.edge_no, edge_num);
            end
            if (rx_valid && rx_timeout) begin
                vectors++;
                miscompares++;
                $display("FAIL both_pulses: got rx_valid=1 rx_timeout=1 required at most one, edge %0d", edge_num);
            end
            if (rx_valid || rx_timeout) begin
                if (q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL spurious_event: got valid=%0b timeout=%0b required no pulse, edge %0d",
                             rx_valid, rx_timeout, edge_num);
                end else begin
                    e = q.pop_front();
                    check("event_edge", edge_num, e.edge_no);
                    check("event_kind", {30'd0, rx_valid, rx_timeout}, {30'd0, e.is_valid, !e.is_valid});
                    check("event_addr", {24'd0, addr_rx}, {24'd0, e.a});
                    check("event_data", {24'd0, data_rx}, {24'd0, e.d});
                    check("event_err",  {24'd0, err_cnt}, {24'd0, e.e});
                    $display("txn edge=%0d %s addr=%02h data=%02h err_cnt=%0d",
                             edge_num, rx_valid ? "pair   " : "timeout", addr_rx, data_rx, err_cnt);
                end
            end
        end
    end

    initial begin
        int r;
        // 1: basic pair, data three cycles after address
        do_reset(2);
        idle(1);
        strobe(8'h12); idle(2); strobe(8'h34); idle(3);

        // 2: timeout, then a pair
        strobe(8'hA5); idle(10);
        strobe(8'h01); strobe(8'h02); idle(2);

        // 3: data exactly on the expiry edge
        strobe(8'hC3); idle(T - 1); strobe(8'h3C); idle(3);

        // 4: four consecutive strobes
        strobe(8'h10); strobe(8'h20); strobe(8'h30); strobe(8'h40); idle(2);

        // 5: reset mid-wait; strobe on the IDLE edge is ignored
        strobe(8'h55); idle(3);
        do_reset(1);
        strobe(8'h99); idle(T + 2);
        strobe(8'h66); strobe(8'h77); idle(2);

        // 6: saturate err_cnt
        for (int i = 0; i < 260; i++) begin
            strobe(8'($urandom)); idle(T);
        end
        idle(1);
        strobe(8'hDE); idle(1); strobe(8'hAD); idle(2);

        // Random traffic with occasional long gaps and resets
        for (int i = 0; i < 500; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 2)       do_reset(1);
            else if (r < 50) strobe(8'($urandom));
            else if (r < 93) idle(1);
            else             idle(int'($urandom_range(T - 2, T + 2)));
        end
        idle(T + 4);

        check("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
